ram_master: RTL and testbench
=============================

Name: ram_master

Overview:
- Initiator-side controller for the team's single-port synchronous RAM (din/addr/we/dout, 1-cycle registered read, no read on write cycles).
- Accepts read/write requests over a valid/ready request channel and sequences the RAM port.
- Returns read data over a valid/ready response channel with backpressure.
- Sits between bus/testbench traffic generators and the RAM instance.

Parameters:
- ADDR_W, 8, RAM address width; depth is 2**ADDR_W.
- DATA_W, 8, RAM data width.
- CNT_W, 16, width of the write and read transaction counters.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1=write, 0=read.
- req_addr  input  ADDR_W  request address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  read data valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  DATA_W  read data.
- ram_we  output  1  to RAM we.
- ram_addr  output  ADDR_W  to RAM addr.
- ram_din  output  DATA_W  to RAM din.
- ram_dout  input  DATA_W  from RAM dout.
- busy  output  1  state != IDLE.
- wr_cnt  output  CNT_W  completed writes, saturating.
- rd_cnt  output  CNT_W  completed reads (response handshakes), saturating.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; req_ready=0; rsp_valid=0; rsp_rdata=0; ram_we=0; ram_addr=0; ram_din=0; wr_cnt=0; rd_cnt=0; busy=0.
- ram_we deasserts immediately on reset. A write not yet clocked into the RAM is dropped. Any read in flight is discarded with no response.
- req_ready = (state==IDLE) and rst high; it rises in the first cycle after reset release.
- A request is accepted on a posedge with req_valid && req_ready. All RAM-side outputs are registered.
- State machine:
  - IDLE: on accept with req_we=1, register ram_addr=req_addr, ram_din=req_wdata, ram_we=1 and go to WR. On accept with req_we=0, register ram_addr=req_addr, ram_we=0 and go to RD1. Otherwise hold; ram_we=0.
  - WR: RAM writes on this edge. Set ram_we=0, increment wr_cnt, go to IDLE. Write occupancy is 2 cycles; maximum write rate is 1 per 2 cycles.
  - RD1: RAM latches dout=mem[ram_addr] on this edge; go to RD2.
  - RD2: capture rsp_rdata=ram_dout, set rsp_valid=1, go to RESP.
  - RESP: hold rsp_valid=1 and rsp_rdata stable until rsp_ready=1. On that edge clear rsp_valid, increment rd_cnt, go to IDLE.
- Read latency: accept edge E0 -> rsp_valid high after E2 (2 cycles).
- If rsp_ready is already high when rsp_valid rises, the handshake completes on the next edge.
- ram_we is 1 only in WR. ram_addr and ram_din hold their last values in all other states.
- No new request is accepted while a response is pending (RESP), so there is no response reordering or loss.
- Read-after-write to the same address returns the new data: the write commits at E1, the read is accepted no earlier than E2, and the RAM reads at E3.
- Addresses use the full ADDR_W with no wrap logic. Address 2**ADDR_W-1 is valid.
- wr_cnt and rd_cnt saturate at all-ones and never wrap.
- req_addr, req_we and req_wdata are sampled only on the accept edge. Changes at other times have no effect.

Test Plan:
- Reset release, idle: rst low 3 cycles then high -> all outputs 0 during reset; req_ready=1 the first cycle after release; busy=0.
- Write 0xA5 to 0x10, then read 0x10 with rsp_ready=1:
  - ram_we=1 for exactly one cycle with ram_addr=0x10, ram_din=0xA5.
  - rsp_valid rises 2 cycles after read accept with rsp_rdata=0xA5.
  - wr_cnt=1, rd_cnt=1.
- Backpressure: read 0xFF (preloaded 0x3C) with rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_rdata=0x3C stable all 5 cycles; req_ready=0; on rsp_ready=1 exactly one handshake, rd_cnt +1.
- Back-to-back traffic: req_valid held high across writes 0x00..0x03 (data 0x11,0x22,0x33,0x44) then reads of same -> writes accepted every 2nd cycle; reads return 0x11,0x22,0x33,0x44 in order.
- Reset mid-operation:
  - Assert rst in WR (ram_we=1) -> ram_we drops asynchronously; a subsequent read of that address returns the old value.
  - Assert rst in RD2 -> no rsp_valid after release.
- Counter saturation with CNT_W=2: 5 writes -> wr_cnt=3 after the 3rd write and remains 3.

Source files
------------

// File: rtl/ram_master.sv
// ram_master: initiator-side sequencer for a single-port synchronous RAM
// (1-cycle registered read, no read on write cycles). Requests arrive on a
// valid/ready channel; read data leaves on a valid/ready response channel
// that honours backpressure. Completed writes and reads are counted with
// saturating counters.
module ram_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    // IDLE: waiting for a request
    // WR  : ram_we is high, RAM commits the write on the next edge
    // RD1 : RAM registers dout on the next edge
    // RD2 : ram_dout is valid, capture it into the response register
    // RESP: response held until the consumer takes it
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t state;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Ready only while idle and out of reset, so nothing is accepted during
    // reset and no request overtakes a pending response.
    assign req_ready = (state == IDLE) && rst;
    assign busy      = (state != IDLE);

    // Request sequencing, RAM port registers, response register and counters.
    // Reset clears ram_we asynchronously, which drops a write not yet
    // clocked into the RAM and discards any read in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ram_we <= 1'b0;
                    if (req_valid) begin
                        ram_addr <= req_addr;
                        if (req_we) begin
                            ram_din <= req_wdata;
                            ram_we  <= 1'b1;
                            state   <= WR;
                        end else begin
                            state <= RD1;
                        end
                    end
                end
                WR: begin
                    // The RAM commits the write on this edge.
                    ram_we <= 1'b0;
                    if (wr_cnt != CNT_MAX) begin
                        wr_cnt <= wr_cnt + CNT_ONE;
                    end
                    state <= IDLE;
                end
                RD1: begin
                    // The RAM registers mem[ram_addr] on this edge.
                    state <= RD2;
                end
                RD2: begin
                    rsp_rdata <= ram_dout;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rd_cnt != CNT_MAX) begin
                            rd_cnt <= rd_cnt + CNT_ONE;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    ram_we    <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: randomized and directed checks of ram_master against a
// reference memory image and saturating transaction counts kept in the bench.
// A behavioural single-port RAM is attached to the RAM port of the main DUT;
// a second instance with 2-bit counters exercises counter saturation.
module tb_ram_master;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_ready;
    logic [7:0] ram_dout;

    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_din;
    logic        busy;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    // Second instance for counter saturation
    logic       s_req_valid;
    logic       s_req_we;
    logic [7:0] s_req_addr;
    logic [7:0] s_req_wdata;
    logic       s_rsp_ready;
    logic [7:0] s_ram_dout;
    logic       s_req_ready;
    logic       s_rsp_valid;
    logic [7:0] s_rsp_rdata;
    logic       s_ram_we;
    logic [7:0] s_ram_addr;
    logic [7:0] s_ram_din;
    logic       s_busy;
    logic [1:0] s_wr_cnt;
    logic [1:0] s_rd_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: expected memory image and expected counts
    logic [7:0] ref_mem [256];
    int wr_exp = 0;
    int rd_exp = 0;

    // Behavioural RAM attached to the main DUT
    logic [7:0] ram_mem [256];

    ram_master #(.ADDR_W(8), .DATA_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .busy      (busy),
        .wr_cnt    (wr_cnt),
        .rd_cnt    (rd_cnt)
    );

    ram_master #(.ADDR_W(8), .DATA_W(8), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .req_valid (s_req_valid),
        .req_ready (s_req_ready),
        .req_we    (s_req_we),
        .req_addr  (s_req_addr),
        .req_wdata (s_req_wdata),
        .rsp_valid (s_rsp_valid),
        .rsp_ready (s_rsp_ready),
        .rsp_rdata (s_rsp_rdata),
        .ram_we    (s_ram_we),
        .ram_addr  (s_ram_addr),
        .ram_din   (s_ram_din),
        .ram_dout  (s_ram_dout),
        .busy      (s_busy),
        .wr_cnt    (s_wr_cnt),
        .rd_cnt    (s_rd_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous RAM: write when we, otherwise registered read
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        else        ram_dout <= ram_mem[ram_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One write through the DUT; called at posedge+1 with the DUT idle
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        check("wr_ready_pre", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        // Scramble request fields after accept; they must have no effect
        req_valid = 1'b0; req_we = 1'($urandom);
        req_addr = 8'($urandom); req_wdata = 8'($urandom);
        check("wr_we_on", 32'(ram_we), 32'd1);
        check("wr_addr", 32'(ram_addr), 32'(a));
        check("wr_din", 32'(ram_din), 32'(d));
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_ready_busy", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        ref_mem[a] = d;
        wr_exp = sat(wr_exp + 1, 65535);
        check("wr_we_off", 32'(ram_we), 32'd0);
        check("wr_cnt", 32'(wr_cnt), 32'(wr_exp));
        check("wr_ready_post", 32'(req_ready), 32'd1);
        $display("write addr=0x%02h data=0x%02h wr_cnt=%0d", a, d, wr_cnt);
    endtask

    // One read; rsp_ready held low for 'delay' cycles after rsp_valid rises
    task automatic do_read(input logic [7:0] a, input int delay);
        check("rd_ready_pre", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'($urandom);
        rsp_ready = 1'b0;
        @(posedge clk); #1;   // accept edge
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = 8'($urandom);
        if (delay == 0) rsp_ready = 1'b1;
        check("rd_busy", 32'(busy), 32'd1);
        check("rd_we", 32'(ram_we), 32'd0);
        check("rd_addr", 32'(ram_addr), 32'(a));
        @(posedge clk); #1;
        check("rd_early", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;   // two cycles after accept
        check("rd_valid", 32'(rsp_valid), 32'd1);
        check("rd_data", 32'(rsp_rdata), 32'(ref_mem[a]));
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_rdata), 32'(ref_mem[a]));
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_rd_cnt", 32'(rd_cnt), 32'(rd_exp));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        rd_exp = sat(rd_exp + 1, 65535);
        check("rd_done_valid", 32'(rsp_valid), 32'd0);
        check("rd_cnt", 32'(rd_cnt), 32'(rd_exp));
        check("rd_ready_post", 32'(req_ready), 32'd1);
        $display("read  addr=0x%02h data=0x%02h delay=%0d rd_cnt=%0d", a, ref_mem[a], delay, rd_cnt);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h55; req_wdata = 8'hAA;
        rsp_ready = 1'b1;
        s_req_valid = 1'b0; s_req_we = 1'b0; s_req_addr = 8'h00; s_req_wdata = 8'h00;
        s_rsp_ready = 1'b0; s_ram_dout = 8'h00;

        // Reset held for 3 cycles with a request pending: nothing may move
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
            check("rst_ram_we", 32'(ram_we), 32'd0);
            check("rst_ram_addr", 32'(ram_addr), 32'd0);
            check("rst_ram_din", 32'(ram_din), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
            check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
            $display("reset cycle %0d", i);
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("rel_req_ready", 32'(req_ready), 32'd1);
        check("rel_busy", 32'(busy), 32'd0);
        $display("reset released");

        // Write 0xA5 to 0x10, read it back with rsp_ready already high
        do_write(8'h10, 8'hA5);
        do_read(8'h10, 0);
        check("dir_wr_cnt", 32'(wr_cnt), 32'd1);
        check("dir_rd_cnt", 32'(rd_cnt), 32'd1);

        // Fill the whole memory so the reference image is fully known
        for (int i = 0; i < 256; i++) do_write(8'(i), 8'($urandom));

        // Backpressure on the top address
        do_write(8'hFF, 8'h3C);
        do_read(8'hFF, 5);

        // Back-to-back writes with req_valid held high
        req_valid = 1'b1; req_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 8'(i); req_wdata = 8'((i + 1) * 17);
            @(posedge clk); #1;
            check("b2b_we_on", 32'(ram_we), 32'd1);
            check("b2b_addr", 32'(ram_addr), 32'(i));
            check("b2b_din", 32'(ram_din), 32'((i + 1) * 17));
            check("b2b_not_ready", 32'(req_ready), 32'd0);
            ref_mem[i] = 8'((i + 1) * 17);
            wr_exp = sat(wr_exp + 1, 65535);
            if (i == 3) req_valid = 1'b0;
            @(posedge clk); #1;
            check("b2b_we_off", 32'(ram_we), 32'd0);
            check("b2b_ready", 32'(req_ready), 32'd1);
            check("b2b_wr_cnt", 32'(wr_cnt), 32'(wr_exp));
            $display("b2b write addr=0x%02h data=0x%02h", 8'(i), ref_mem[i]);
        end
        // Back-to-back reads with req_valid held high
        req_valid = 1'b1; req_we = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 8'(i);
            @(posedge clk); #1;
            check("b2b_rd_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
            check("b2b_rd_early", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
            check("b2b_rd_valid", 32'(rsp_valid), 32'd1);
            check("b2b_rd_data", 32'(rsp_rdata), 32'((i + 1) * 17));
            @(posedge clk); #1;
            rd_exp = sat(rd_exp + 1, 65535);
            check("b2b_rd_done", 32'(rsp_valid), 32'd0);
            check("b2b_rd_cnt", 32'(rd_cnt), 32'(rd_exp));
            if (i == 3) req_valid = 1'b0;
            $display("b2b read  addr=0x%02h data=0x%02h", 8'(i), rsp_rdata);
        end
        rsp_ready = 1'b0;

        // Reset while in WR: the pending write must be dropped
        do_write(8'h20, 8'h5A);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'hC3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rwr_we_on", 32'(ram_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rwr_we_async", 32'(ram_we), 32'd0);
        check("rwr_busy", 32'(busy), 32'd0);
        check("rwr_ready", 32'(req_ready), 32'd0);
        wr_exp = 0; rd_exp = 0;
        @(posedge clk); @(posedge clk); #3 rst = 1'b1;
        #1;
        check("rwr_wr_cnt", 32'(wr_cnt), 32'd0);
        check("rwr_ready_rel", 32'(req_ready), 32'd1);
        $display("reset during write");
        @(posedge clk); #1;
        do_read(8'h20, 1);

        // Reset while in RD2: no response may appear afterwards
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h30; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rrd_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rrd_valid_rst", 32'(rsp_valid), 32'd0);
        check("rrd_busy_rst", 32'(busy), 32'd0);
        wr_exp = 0; rd_exp = 0;
        @(posedge clk); #3 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rrd_no_rsp", 32'(rsp_valid), 32'd0);
            check("rrd_rd_cnt", 32'(rd_cnt), 32'd0);
        end
        rsp_ready = 1'b0;
        $display("reset during read");

        // Randomized traffic against the reference image
        for (int n = 0; n < 80; n++) begin
            logic [7:0] a;
            int pick;
            pick = int'($urandom_range(0, 9));
            if (pick == 0)      a = 8'h00;
            else if (pick == 1) a = 8'hFF;
            else                a = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
            else                           do_read(a, int'($urandom_range(0, 3)));
        end

        // Counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            s_req_valid = 1'b1; s_req_we = 1'b1;
            s_req_addr = 8'(i); s_req_wdata = 8'($urandom);
            @(posedge clk); #1;
            s_req_valid = 1'b0;
            check("sat_we_on", 32'(s_ram_we), 32'd1);
            check("sat_addr", 32'(s_ram_addr), 32'(i));
            check("sat_din", 32'(s_ram_din), 32'(s_req_wdata));
            check("sat_busy", 32'(s_busy), 32'd1);
            @(posedge clk); #1;
            check("sat_wr_cnt", 32'(s_wr_cnt), 32'(sat(i + 1, 3)));
            check("sat_ready", 32'(s_req_ready), 32'd1);
            check("sat_rsp_valid", 32'(s_rsp_valid), 32'd0);
            check("sat_rsp_rdata", 32'(s_rsp_rdata), 32'd0);
            check("sat_rd_cnt", 32'(s_rd_cnt), 32'd0);
            $display("sat write %0d wr_cnt=%0d", i, s_wr_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
